// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider (div_unit / div_step).
//   - FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   - iteration counter width helper: $clog2(width)+1
//   - DIV_ZERO_QUOT: quotient returned on divide-by-zero (all ones)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } div_state_e;

  // Wide enough for any supported operand width; users slice the low bits.
  localparam int DIV_MAX_WIDTH = 64;
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem          in  WIDTH  partial remainder (always < divisor on entry)
//   dividend_msb in  1      next dividend bit shifted into the remainder
//   divisor      in  WIDTH  divisor magnitude
//   rem_next     out WIDTH  partial remainder after this iteration
//   quot_bit     out 1      quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem, dividend_msb};

  // rem < divisor guarantees the true difference fits in WIDTH bits, so a
  // WIDTH-bit subtraction is exact whenever the subtract is taken, even
  // when the shifted value overflowed into bit WIDTH.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign quot_bit = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor);
  assign rem_next = quot_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in EX. Produces
// {HI=remainder, LO=quotient} and requests a pipeline stall while busy.
// Optional build macro: DIV_EARLY_OUT_EN -- when |opa| < |opb| (opb != 0)
// the result {opa, 0} is returned without iterating.
// Ports:
//   clk           in  1        clock, all state on posedge
//   resetn        in  1        synchronous active-low reset
//   div_start     in  1        operation request, held until div_ready
//   div_signed    in  1        1 = DIV (two's complement), 0 = DIVU
//   div_opa       in  WIDTH    dividend
//   div_opb       in  WIDTH    divisor
//   div_cancel    in  1        abort current operation (flush/exception)
//   div_result    out 2*WIDTH  {remainder, quotient}, qualify with div_ready
//   div_ready     out 1        one-cycle result-valid pulse
//   stall_req_ex  out 1        stall request to the pipeline controller
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for div_start; latches operand magnitudes and signs
// BUSY  | one quotient bit per cycle, MSB first, WIDTH iterations
// DONE  | result registered, div_ready pulses, always returns to IDLE
// -----------------------------------------------------------------------------
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   div_opa,
  input  logic [WIDTH-1:0]   div_opb,
  input  logic               div_cancel,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_ready,
  output logic               stall_req_ex
);

  localparam int CNT_W = div_cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_QUOT = DIV_ZERO_QUOT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, refilled with quotient bits
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem;
  logic             quot_neg;
  logic             rem_neg;
  logic             ready_q;

  logic             opa_neg;
  logic             opb_neg;
  logic [WIDTH-1:0] opa_abs;
  logic [WIDTH-1:0] opb_abs;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quot_raw;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which is the correct
  // unsigned magnitude.
  assign opa_neg = div_signed & div_opa[WIDTH-1];
  assign opb_neg = div_signed & div_opb[WIDTH-1];
  assign opa_abs = opa_neg ? -div_opa : div_opa;
  assign opb_abs = opb_neg ? -div_opb : div_opb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (step_rem),
    .quot_bit     (step_qbit)
  );

  // Fix-up for the last iteration's outputs, folded into the DONE entry.
  assign quot_raw = {dvd[WIDTH-2:0], step_qbit};
  assign quot_fix = quot_neg ? -quot_raw : quot_raw;
  assign rem_fix  = rem_neg ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      quot_neg   <= 1'b0;
      rem_neg    <= 1'b0;
      div_result <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (div_cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div_start) begin
              dvd      <= opa_abs;
              dvs      <= opb_abs;
              rem      <= '0;
              quot_neg <= opa_neg ^ opb_neg;
              rem_neg  <= opa_neg;
              cnt      <= '0;
              if (div_opb == '0) begin
                div_result <= {div_opa, ZERO_QUOT};
                ready_q    <= 1'b1;
                state      <= DONE;
              end
`ifdef DIV_EARLY_OUT_EN
              else if (opa_abs < opb_abs) begin
                div_result <= {div_opa, {WIDTH{1'b0}}};
                ready_q    <= 1'b1;
                state      <= DONE;
              end
`endif
              else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            // Dropping the request mid-flight means EX no longer holds the
            // instruction; abandon the work like a cancel.
            if (!div_start) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              dvd <= quot_raw;
              rem <= step_rem;
              cnt <= cnt + CNT_W'(1);
              if (cnt == LAST_ITER) begin
                div_result <= {rem_fix, quot_fix};
                ready_q    <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // A cancel arriving in the DONE cycle suppresses the pulse so a flushed
  // instruction never writes HI/LO.
  assign div_ready    = ready_q & ~div_cancel;
  assign stall_req_ex = div_start & ~div_ready & ~div_cancel;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           div_start = 1'b0;
  logic           div_signed = 1'b0;
  logic [W-1:0]   div_opa = '0;
  logic [W-1:0]   div_opb = '0;
  logic           div_cancel = 1'b0;
  logic [2*W-1:0] div_result;
  logic           div_ready;
  logic           stall_req_ex;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: one outstanding operation
  bit          model_active = 1'b0;
  int          start0 = 0;
  int          exp_ready_cyc = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] got_res = '0;
  int          got_lat = -1;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_opa      (div_opa),
    .div_opb      (div_opb),
    .div_cancel   (div_cancel),
    .div_result   (div_result),
    .div_ready    (div_ready),
    .stall_req_ex (stall_req_ex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // MIPS semantics from plain arithmetic: truncating division, remainder
  // carries the dividend's sign.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
`ifdef DIV_EARLY_OUT_EN
    longint ma;
    longint mb;
`endif
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    ma = s ? longint'($signed(a)) : longint'(a);
    mb = s ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // compare process: every cycle, ready/stall against the model, result on ready
  always @(negedge clk) begin
    bit er;
    bit es;
    er = model_active && (cyc == exp_ready_cyc) && !div_cancel;
    es = div_start && !er && !div_cancel;
    check1("ready", div_ready, er);
    check1("stall", stall_req_ex, es);
    if (er) begin
      check64("result", div_result, exp_res);
      got_res = div_result;
      got_lat = cyc - start0;
    end
  end

  // Caller is positioned just after a posedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    div_opa       = a;
    div_opb       = b;
    div_signed    = s;
    div_start     = 1'b1;
    exp_res       = model_div(a, b, s);
    start0        = cyc;
    exp_ready_cyc = cyc + model_lat(a, b, s);
    model_active  = 1'b1;
    got_lat       = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    launch(a, b, s);
    while (cyc < exp_ready_cyc + 1) tick();
    div_start    = 1'b0;
    model_active = 1'b0;
  endtask

  int n0;

  initial begin
    resetn = 1'b0;
    repeat (3) tick();
    check64("reset_result", div_result, 64'd0);
    check1("reset_ready", div_ready, 1'b0);
    resetn = 1'b1;
    tick();

    do_div(32'd100, 32'd7, 1'b0);
    check_int("lat_100_7", got_lat, 33);
    check64("res_100_7", got_res, 64'h0000_0002_0000_000E);

    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check64("res_m7_2", got_res, 64'hFFFF_FFFF_FFFF_FFFD);

    do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    check64("res_7_m2", got_res, 64'h0000_0001_FFFF_FFFD);

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check64("res_min_m1_s", got_res, 64'h0000_0000_8000_0000);

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check64("res_min_m1_u", got_res, 64'h8000_0000_0000_0000);

    do_div(32'd5, 32'd0, 1'b0);
    check_int("lat_div0", got_lat, 1);
    check64("res_5_0", got_res, 64'h0000_0005_FFFF_FFFF);

    do_div(32'd3, 32'd9, 1'b0);
    check64("res_3_9", got_res, 64'h0000_0003_0000_0000);
`ifdef DIV_EARLY_OUT_EN
    check_int("lat_3_9", got_lat, 1);
`else
    check_int("lat_3_9", got_lat, 33);
`endif

    // model-only vectors
    do_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    check64("res_m100_m7", got_res, 64'hFFFF_FFFE_0000_000E);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    do_div(32'd123456789, 32'd1000, 1'b1);

    // cancel at cycle 10, idle at 11, restart at 12 completes at 45
    launch(32'd100, 32'd7, 1'b0);
    n0 = start0;
    repeat (10) tick();
    div_cancel   = 1'b1;
    model_active = 1'b0;
    tick();
    div_cancel = 1'b0;
    div_start  = 1'b0;
    tick();
    do_div(32'd1000, 32'd3, 1'b0);
    check_int("cancel_restart_done", got_lat + (start0 - n0), 45);
    check64("res_1000_3", got_res, 64'h0000_0001_0000_014D);

    // cancel beats start in IDLE
    div_opa = 32'd9; div_opb = 32'd0; div_start = 1'b1; div_cancel = 1'b1;
    tick();
    div_start = 1'b0; div_cancel = 1'b0;
    tick();

    // cancel in the DONE cycle suppresses the pulse
    launch(32'd5, 32'd0, 1'b0);
    tick();
    div_cancel = 1'b1;
    tick();
    div_cancel   = 1'b0;
    div_start    = 1'b0;
    model_active = 1'b0;
    tick();

    // start dropped while busy acts as cancel
    launch(32'd77, 32'd5, 1'b0);
    repeat (5) tick();
    div_start    = 1'b0;
    model_active = 1'b0;
    repeat (40) tick();
    do_div(32'd77, 32'd5, 1'b0);
    check64("res_77_5", got_res, 64'h0000_0002_0000_000F);

    // reset mid-operation at cycle 5
    launch(32'd100, 32'd7, 1'b0);
    repeat (5) tick();
    resetn       = 1'b0;
    model_active = 1'b0;
    tick();
    resetn    = 1'b1;
    div_start = 1'b0;
    check64("midreset_result", div_result, 64'd0);
    check1("midreset_ready", div_ready, 1'b0);
    tick();
    do_div(32'd100, 32'd7, 1'b0);
    check_int("post_reset_lat", got_lat, 33);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
